// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester
// encoding and grant-vector bit positions.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        P_RD = 2'd1,
        D_RD = 2'd2
    } arbState_t;

    typedef enum logic {
        PIPE  = 1'b0,
        DEBUG = 1'b1
    } requester_t;

    // Bit positions inside the one-hot grant vector.
    localparam int GNT_PIPE  = 0;
    localparam int GNT_DEBUG = 1;

    function automatic requester_t granteeOf(logic debugGranted);
        return debugGranted ? DEBUG : PIPE;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant decision for the data-memory arbiter.
// Ports: p_req/d_req requests, last_gnt previous winner, grant one-hot
// {debug, pipe}. DATA_MEM_ARB_ROUND_ROBIN_EN alternates on contention;
// otherwise the pipeline always wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       p_req,
    input  logic       d_req,
    input  requester_t last_gnt,
    output logic [1:0] grant
);

`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        grant = 2'b00;
        if (p_req && d_req) begin
            // Hand the port to whoever did not win last time.
            if (last_gnt == PIPE) begin
                grant[GNT_DEBUG] = 1'b1;
            end else begin
                grant[GNT_PIPE] = 1'b1;
            end
        end else begin
            grant[GNT_PIPE]  = p_req;
            grant[GNT_DEBUG] = d_req;
        end
    end
`else
    logic unusedLastGnt;
    assign unusedLastGnt = last_gnt;

    always_comb begin
        grant = 2'b00;
        if (p_req) begin
            grant[GNT_PIPE] = 1'b1;
        end else if (d_req) begin
            grant[GNT_DEBUG] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data memory between the pipeline MEM stage and
// a debug/loader port.
// Ports: clock, reset (async active-low); pipeline p_req/p_we/p_addr/
// p_wdata -> p_rdata/p_stall; debug d_req/d_we/d_addr/d_wdata ->
// d_gnt/d_valid/d_rdata; memory mem_addr/mem_we/mem_din, mem_dout
// (1-cycle read latency).
// Option: DATA_MEM_ARB_ROUND_ROBIN_EN selects alternating grants.
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [31:0]       p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic [DATA_W-1:0] p_rdata,
    output logic              p_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    arbState_t         state;
    requester_t        lastGnt;
    logic [DATA_W-1:0] pHold;
    logic [DATA_W-1:0] dHold;
    logic [1:0]        pickGnt;
    logic              pGnt;
    logic              dGnt;
    logic              unusedAddr;

    // Byte-offset and out-of-range address bits are deliberately dropped.
    assign unusedAddr = ^{p_addr[31:ADDR_W+2], p_addr[1:0],
                          d_addr[31:ADDR_W+2], d_addr[1:0]};

    // Requests are masked while reset is low so nothing reaches memory.
    mem_arb_pick uPick (
        .p_req    (p_req & reset),
        .d_req    (d_req & reset),
        .last_gnt (lastGnt),
        .grant    (pickGnt)
    );

    assign pGnt = (state == IDLE) & pickGnt[GNT_PIPE];
    assign dGnt = (state == IDLE) & pickGnt[GNT_DEBUG];

    always_comb begin
        mem_addr = p_addr[ADDR_W+1:2];
        mem_din  = p_wdata;
        mem_we   = 1'b0;
        unique case (1'b1)
            dGnt: begin
                mem_addr = d_addr[ADDR_W+1:2];
                mem_din  = d_wdata;
                mem_we   = d_we;
            end
            pGnt: begin
                mem_we = p_we;
            end
            default: ;
        endcase
    end

    assign d_gnt = dGnt;

    // A granted write retires at once; a read is released in P_RD.
    assign p_stall = p_req & ~(pGnt & p_we) & (state != P_RD);

    // Memory data is live during the response cycle, then latched.
    assign p_rdata = (state == P_RD) ? mem_dout : pHold;
    assign d_rdata = (state == D_RD) ? mem_dout : dHold;
    assign d_valid = (state == D_RD);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            lastGnt <= DEBUG;
            pHold   <= '0;
            dHold   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pGnt || dGnt) begin
                        lastGnt <= granteeOf(dGnt);
                    end
                    if (pGnt && !p_we) begin
                        state <= P_RD;
                    end else if (dGnt && !d_we) begin
                        state <= D_RD;
                    end
                end
                P_RD: begin
                    pHold <= mem_dout;
                    state <= IDLE;
                end
                D_RD: begin
                    dHold <= mem_dout;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have port clock, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports p_req, p_we (input, 1), p_addr (input, 32, byte address), p_wdata (input, DATA_W): the pipeline MEM-stage request.
REQ-006 SHALL have ports p_rdata (output, DATA_W) and p_stall (output, 1): the pipeline response and the freeze request.
REQ-007 SHALL have ports d_req, d_we (input, 1), d_addr (input, 32, byte address), d_wdata (input, DATA_W): the debug/loader request.
REQ-008 SHALL have ports d_gnt, d_valid (output, 1) and d_rdata (output, DATA_W): the debug response.
REQ-009 SHALL have ports mem_addr (output, ADDR_W), mem_we (output, 1), mem_din (output, DATA_W), mem_dout (input, DATA_W): the single-port data memory, read latency 1 cycle.

Function
REQ-010 SHALL implement FSM states IDLE, P_RD, D_RD.
REQ-011 SHALL, in IDLE, grant at most one requester per cycle, combinationally; the granted request drives mem_addr/mem_we/mem_din that cycle.
REQ-012 SHALL map mem_addr = granted addr[ADDR_W+1:2]; addr[1:0] ignored; upper bits ignored.
REQ-013 SHALL complete a granted write in its grant cycle, with the FSM staying in IDLE.
REQ-014 SHALL, on a granted read, go to P_RD or D_RD; next cycle present mem_dout on p_rdata (P_RD) or d_rdata with d_valid=1 (D_RD), then return to IDLE.
REQ-015 SHALL drive p_stall = p_req AND NOT (IDLE with pipeline write granted) AND NOT (state==P_RD).
REQ-016 SHALL pulse d_gnt for exactly the grant cycle; the debug requester holds d_req/d_addr/d_we/d_wdata stable until d_gnt.
REQ-017 SHALL grant nothing in P_RD/D_RD, with mem_we=0; requests wait.
REQ-018 SHALL hold mem_we=0 whenever no write is granted; p_rdata and d_rdata hold their last value outside response cycles.
REQ-019 SHALL record the last granted requester (last_gnt) on every grant.
REQ-020 SHALL treat simultaneous writes to the same address as ordinary contention: one is granted, the other waits; no merging.

Reset
REQ-021 SHALL, on reset low, immediately force state=IDLE, last_gnt=DEBUG, and p_rdata=0, d_rdata=0, d_valid=0, d_gnt=0, mem_we=0; p_stall then follows REQ-015.
REQ-022 SHALL drop a read in flight when reset is asserted mid-operation, with no d_valid afterwards.

Configuration
REQ-023 SHALL, with macro DATA_MEM_ARB_ROUND_ROBIN_EN defined, grant the requester not equal to last_gnt when both request in IDLE.
REQ-024 SHALL, without DATA_MEM_ARB_ROUND_ROBIN_EN, always grant the pipeline when both request; debug is served only when p_req=0.

Structure
REQ-025 SHALL place the state enum (IDLE/P_RD/D_RD) and the requester encoding (PIPE/DEBUG) in shared package mem_arb_pkg.
REQ-026 SHALL implement the grant decision in sub-module mem_arb_pick (inputs p_req, d_req, last_gnt; outputs one-hot grant).

Verification
REQ-027 SHALL cover: pipeline read, p_addr=0x10, memory word 4=0xDEADBEEF -> p_stall=1 for 1 cycle, then p_stall=0 with p_rdata=0xDEADBEEF.
REQ-028 SHALL cover: pipeline write, p_addr=0x08, p_wdata=0x12345678 -> mem_we=1, mem_addr=2 in the same cycle, p_stall=0.
REQ-029 SHALL cover: p_req and d_req both reads held continuously with ROUND_ROBIN_EN -> grants alternate PIPE, DEBUG, PIPE (first PIPE after reset); without the macro -> DEBUG never granted.
REQ-030 SHALL cover: debug read, d_addr=0x3FC -> d_gnt pulse, mem_addr=0xFF; next cycle d_valid=1 with d_rdata = word 255.
REQ-031 SHALL cover: reset asserted in D_RD -> outputs zero immediately; d_valid is never asserted for the dropped read.
REQ-032 SHALL cover: pipeline write during D_RD -> p_stall=1 that cycle; write is granted the following IDLE cycle.
